toy_dmem_resp: RTL

//  Data-memory responder: the target end of the RISC_TOY data bus (DREQ/DRW/DADDR/DWDATA/DRDATA).

---
 rtl/toy_mem_pkg.sv | 27 ++
 rtl/toy_dmem_wbuf.sv | 40 ++++
 rtl/toy_dmem_resp.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/toy_mem_pkg.sv
// Shared constants and types for the RISC_TOY data-memory responder.
// Bus encodings, out-of-range read value, port-operation enum and address decode helper.
package toy_mem_pkg;

  localparam int          WAW       = 30;
  localparam logic        DRW_READ  = 1'b0;
  localparam logic        DRW_WRITE = 1'b1;
  localparam logic [31:0] OOR_RDATA = 32'h0;

  typedef enum logic [1:0] {
    PORT_IDLE,
    PORT_READ,
    PORT_WRITE
  } port_op_e;

  typedef struct packed {
    logic rd;   // in-range read
    logic wr;   // in-range write
    logic oor;  // any access outside the SRAM
  } dreq_dec_t;

  // Word address is in range when every bit above the SRAM index is zero.
  function automatic logic addr_in_range(input logic [WAW-1:0] addr, input int aw);
    return (addr >> aw) == '0;
  endfunction

endpackage

// File: rtl/toy_dmem_wbuf.sv
// One-entry posted-store buffer: capture/merge on write, clear on drain,
// plus the address compare used for read forwarding and eviction.
module toy_dmem_wbuf
  import toy_mem_pkg::*;
#(
  parameter int BW = 32,
  parameter int AW = 10
) (
  input  logic          CLK,
  input  logic          RSTN,
  input  logic          wr,
  input  logic          drain,
  input  logic [AW-1:0] addr,
  input  logic [BW-1:0] din,
  output logic          wb_v,
  output logic [AW-1:0] wb_a,
  output logic [BW-1:0] wb_d,
  output logic          hit,
  output logic          evict
);

  assign hit   = wb_v && (wb_a == addr);
  // A write to a different address pushes the old entry out to SRAM the same cycle.
  assign evict = wr && wb_v && !hit;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      wb_v <= 1'b0;
      wb_a <= '0;
      wb_d <= '0;
    end else if (wr) begin
      wb_v <= 1'b1;
      wb_a <= addr;
      wb_d <= din;
    end else if (drain) begin
      wb_v <= 1'b0;
    end
  end

endmodule

// File: rtl/toy_dmem_resp.sv
// RISC_TOY data-bus target: address decode, SRAM port mux (read > drain), read-return pipe.
// Optional sticky out-of-range capture when DMEM_ERR_CAPTURE_EN is defined.
module toy_dmem_resp
  import toy_mem_pkg::*;
#(
  parameter int BW    = 32,
  parameter int AW    = 10,
  parameter int ENTRY = 1024
) (
  input  logic           CLK,
  input  logic           RSTN,
  input  logic           DREQ,
  input  logic           DRW,
  input  logic [WAW-1:0] DADDR,
  input  logic [BW-1:0]  DWDATA,
  output logic [BW-1:0]  DRDATA,
  output logic           M_CSN,
  output logic           M_WEN,
  output logic [AW-1:0]  M_A,
  output logic [BW-1:0]  M_DI,
  input  logic [BW-1:0]  M_DOUT,
  output logic           WB_VALID,
  output logic           ERR,
  output logic [WAW-1:0] ERR_ADDR
);

  localparam int DEC_W = $clog2(ENTRY);

  dreq_dec_t     dec;
  logic          in_rng;
  logic          free;
  logic          drain_go;
  port_op_e      op;

  logic          wb_v;
  logic [AW-1:0] wb_a;
  logic [BW-1:0] wb_d;
  logic          hit;
  logic          evict;

  logic          rd_pend;
  logic          oor_pend;
  logic          hit_q;
  logic [BW-1:0] hit_d_q;
  logic [BW-1:0] hold;

  assign in_rng  = addr_in_range(DADDR, DEC_W);
  assign dec.rd  = DREQ && (DRW == DRW_READ)  && in_rng;
  assign dec.wr  = DREQ && (DRW == DRW_WRITE) && in_rng;
  assign dec.oor = DREQ && !in_rng;

  // Dropped out-of-range stores leave the port idle, so the buffer may drain.
  assign free     = !DREQ || ((DRW == DRW_WRITE) && !in_rng);
  assign drain_go = free && wb_v;

  toy_dmem_wbuf #(.BW(BW), .AW(AW)) u_wbuf (
    .CLK   (CLK),
    .RSTN  (RSTN),
    .wr    (dec.wr),
    .drain (drain_go),
    .addr  (DADDR[AW-1:0]),
    .din   (DWDATA),
    .wb_v  (wb_v),
    .wb_a  (wb_a),
    .wb_d  (wb_d),
    .hit   (hit),
    .evict (evict)
  );

  assign WB_VALID = wb_v;

  always_comb begin
    op = PORT_IDLE;
    if (dec.rd)                  op = PORT_READ;
    else if (evict || drain_go)  op = PORT_WRITE;
  end

  always_comb begin
    M_CSN = 1'b1;
    M_WEN = 1'b1;
    M_A   = '0;
    M_DI  = '0;
    case (op)
      PORT_READ: begin
        M_CSN = 1'b0;
        M_A   = DADDR[AW-1:0];
      end
      PORT_WRITE: begin
        M_CSN = 1'b0;
        M_WEN = 1'b0;
        M_A   = wb_a;
        M_DI  = wb_d;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      rd_pend  <= 1'b0;
      oor_pend <= 1'b0;
      hit_q    <= 1'b0;
      hit_d_q  <= '0;
      hold     <= '0;
    end else begin
      rd_pend  <= dec.rd;
      oor_pend <= dec.oor && (DRW == DRW_READ);
      hit_q    <= hit;
      hit_d_q  <= wb_d;
      if (rd_pend || oor_pend) hold <= DRDATA;
    end
  end

  // Return cycle is combinational from SRAM so back-to-back reads stream one per cycle.
  always_comb begin
    DRDATA = hold;
    if (rd_pend)       DRDATA = hit_q ? hit_d_q : M_DOUT;
    else if (oor_pend) DRDATA = BW'(OOR_RDATA);
  end

`ifdef DMEM_ERR_CAPTURE_EN
  logic           err_q;
  logic [WAW-1:0] err_addr_q;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      err_q      <= 1'b0;
      err_addr_q <= '0;
    end else if (dec.oor && !err_q) begin
      err_q      <= 1'b1;
      err_addr_q <= DADDR;
    end
  end

  assign ERR      = err_q;
  assign ERR_ADDR = err_addr_q;
`else
  assign ERR      = 1'b0;
  assign ERR_ADDR = '0;
`endif

endmodule
